dsp_post_adder_acc: RTL and testbench

Post-adder / accumulator stage of the DSP48A1 slice model, sitting directly downstream of the X and Z operand multiplexers (`Mux2x1` instances selecting registered or bypassed paths). It adds or subtracts the selected X operand and carry-in to or from a Z operand chosen from zero, the cascade input, the C port or its own P feedback. It produces the registered P result, carry-out, the P cascade output and a valid flag with an accumulation-run counter.

---
 rtl/dsp_post_adder_acc.sv | 106 ++++++++++
 tb/tb_dsp_post_adder_acc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_post_adder_acc.sv
// Post-adder / accumulator of the DSP48A1 slice: Z +/- (X + cin) with optional P
// register, cascade output, valid tracking and a saturating accumulation-run counter.
module dsp_post_adder_acc #(
  parameter int WIDTH = 48,
  parameter int PREG  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce_p,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] pcin,
  input  logic [1:0]       z_sel,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] pcout,
  output logic             carry_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] acc_cnt,
  output logic             cfg_err
);

  localparam logic FB_ILLEGAL = (PREG == 0);

  logic [WIDTH-1:0] w_p_fb;
  logic [WIDTH-1:0] w_z_p0;
  logic [WIDTH:0]   w_sum_p0;
  logic [CNT_W-1:0] r_cnt_p1;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage 0: Z selection and post-adder (wraps modulo 2^(WIDTH+1))
  always_comb begin
    w_z_p0 = '0;
    case (z_sel)
      2'd0: w_z_p0 = '0;
      2'd1: w_z_p0 = pcin;
      2'd2: w_z_p0 = w_p_fb;
      2'd3: w_z_p0 = c_in;
      default: w_z_p0 = '0;
    endcase
  end

  always_comb begin
    if (sub)
      w_sum_p0 = {1'b0, w_z_p0} - ({1'b0, x_in} + (WIDTH+1)'(cin));
    else
      w_sum_p0 = {1'b0, w_z_p0} + {1'b0, x_in} + (WIDTH+1)'(cin);
  end

  assign cfg_err = FB_ILLEGAL & (z_sel == 2'd2);

  // Stage 1: P register (or bypass when PREG=0)
  generate
    if (PREG != 0) begin : g_preg
      logic [WIDTH-1:0] r_p_p1;
      logic             r_carry_p1;
      logic             r_vld_p1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_p_p1     <= '0;
          r_carry_p1 <= 1'b0;
          r_vld_p1   <= 1'b0;
        end else if (ce_p) begin
          r_p_p1     <= w_sum_p0[WIDTH-1:0];
          r_carry_p1 <= w_sum_p0[WIDTH];
          r_vld_p1   <= valid_in;
        end
      end

      assign w_p_fb    = r_p_p1;
      assign p_out     = r_p_p1;
      assign carry_out = r_carry_p1;
      assign valid_out = r_vld_p1;
    end else begin : g_nopreg
      // Feedback would be a combinational loop here, so Z=P reads as zero.
      assign w_p_fb    = '0;
      assign p_out     = w_sum_p0[WIDTH-1:0];
      assign carry_out = w_sum_p0[WIDTH];
      assign valid_out = valid_in;
    end
  endgenerate

  assign pcout = p_out;

  // Accumulation-run counter, registered regardless of PREG
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt_p1 <= '0;
    else if (ce_p && valid_in) begin
      if (z_sel == 2'd2)
        r_cnt_p1 <= f_sat_inc(r_cnt_p1);
      else
        r_cnt_p1 <= CNT_W'(1);
    end
  end

  assign acc_cnt = r_cnt_p1;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Scenario bench for dsp_post_adder_acc: PREG=1, PREG=0 and CNT_W=2 instances
// share stimulus; a behavioural model supplies expectations for random traffic.
module tb_dsp_post_adder_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce_p = 1'b1;
  logic        valid_in = 1'b0;
  logic [47:0] x_in = '0;
  logic [47:0] c_in = '0;
  logic [47:0] pcin = '0;
  logic [1:0]  z_sel = 2'd0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;

  logic [47:0] p1_p, p1_pc, p0_p, p0_pc, c2_p, c2_pc;
  logic        p1_c, p1_v, p1_e, p0_c, p0_v, p0_e, c2_c, c2_v, c2_e;
  logic [15:0] p1_cnt, p0_cnt;
  logic [1:0]  c2_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [47:0] ALL1 = 48'hFFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  dsp_post_adder_acc #(.WIDTH(48), .PREG(1), .CNT_W(16)) u_p1 (
    .clk(clk), .rst_n(rst_n), .ce_p(ce_p), .valid_in(valid_in), .x_in(x_in),
    .c_in(c_in), .pcin(pcin), .z_sel(z_sel), .sub(sub), .cin(cin),
    .p_out(p1_p), .pcout(p1_pc), .carry_out(p1_c), .valid_out(p1_v),
    .acc_cnt(p1_cnt), .cfg_err(p1_e));

  dsp_post_adder_acc #(.WIDTH(48), .PREG(0), .CNT_W(16)) u_p0 (
    .clk(clk), .rst_n(rst_n), .ce_p(ce_p), .valid_in(valid_in), .x_in(x_in),
    .c_in(c_in), .pcin(pcin), .z_sel(z_sel), .sub(sub), .cin(cin),
    .p_out(p0_p), .pcout(p0_pc), .carry_out(p0_c), .valid_out(p0_v),
    .acc_cnt(p0_cnt), .cfg_err(p0_e));

  dsp_post_adder_acc #(.WIDTH(48), .PREG(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .ce_p(ce_p), .valid_in(valid_in), .x_in(x_in),
    .c_in(c_in), .pcin(pcin), .z_sel(z_sel), .sub(sub), .cin(cin),
    .p_out(c2_p), .pcout(c2_pc), .carry_out(c2_c), .valid_out(c2_v),
    .acc_cnt(c2_cnt), .cfg_err(c2_e));

  // Reference arithmetic: 49-bit wrap of Z + (X+cin) or Z - (X+cin)
  function automatic logic [48:0] f_alu(input logic [47:0] z, input logic [47:0] x,
                                        input logic c, input logic s);
    logic [48:0] a, b;
    a = {1'b0, z};
    b = {1'b0, x} + {48'd0, c};
    return s ? (a - b) : (a + b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (p1_p !== 48'd0 || p1_c !== 1'b0 || p1_v !== 1'b0 || p1_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_init: p=%0d c=%0b v=%0b cnt=%0d want all 0", p1_p, p1_c, p1_v, p1_cnt);
    end
    rst_n = 1'b1;
    x_in = 48'd5; c_in = 48'd7; z_sel = 2'd3; sub = 1'b0; cin = 1'b0;
    valid_in = 1'b1; ce_p = 1'b1;
    tick();
    tick();
    total++; if (p1_p !== 48'd12) begin
      bad++; $display("FAIL reset_pre: p=%0d want 12", p1_p);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (p1_p !== 48'd0 || p1_pc !== 48'd0 || p1_c !== 1'b0 || p1_v !== 1'b0 || p1_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_async: p=%0d pc=%0d c=%0b v=%0b cnt=%0d want all 0",
                      p1_p, p1_pc, p1_c, p1_v, p1_cnt);
    end
    #1;
    rst_n = 1'b1;
    tick();
    total++; if (p1_p !== 48'd12 || p1_v !== 1'b1 || p1_cnt !== 16'd1) begin
      bad++; $display("FAIL reset_release: p=%0d v=%0b cnt=%0d want 12 1 1", p1_p, p1_v, p1_cnt);
    end
  endtask

  task automatic test_add_sub();
    z_sel = 2'd3; c_in = 48'd10; x_in = 48'd3; cin = 1'b1; sub = 1'b0; valid_in = 1'b1;
    tick();
    total++; if (p1_p !== 48'd14 || p1_c !== 1'b0) begin
      bad++; $display("FAIL add: p=%0d c=%0b want 14 0", p1_p, p1_c);
    end
    sub = 1'b1;
    tick();
    total++; if (p1_p !== 48'd6 || p1_c !== 1'b0) begin
      bad++; $display("FAIL sub: p=%0d c=%0b want 6 0", p1_p, p1_c);
    end
    c_in = 48'd2; x_in = 48'd3; cin = 1'b0; sub = 1'b1;
    tick();
    total++; if (p1_p !== ALL1 || p1_c !== 1'b1 || p1_pc !== ALL1) begin
      bad++; $display("FAIL sub_borrow: p=%h c=%0b pc=%h want %h 1", p1_p, p1_c, p1_pc, ALL1);
    end
  endtask

  task automatic test_carry_wrap();
    z_sel = 2'd3; c_in = ALL1; x_in = 48'd1; cin = 1'b0; sub = 1'b0;
    tick();
    total++; if (p1_p !== 48'd0 || p1_c !== 1'b1) begin
      bad++; $display("FAIL carry_wrap: p=%h c=%0b want 0 1", p1_p, p1_c);
    end
  endtask

  task automatic test_accumulate();
    logic [47:0] exp_p [5] = '{48'd4, 48'd8, 48'd12, 48'd12, 48'd16};
    logic [15:0] exp_c [5] = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd4};
    logic        ce_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    sub = 1'b0; cin = 1'b0; x_in = 48'd4; valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      z_sel = (i == 0) ? 2'd0 : 2'd2;
      ce_p = ce_seq[i];
      tick();
      total++; if (p1_p !== exp_p[i] || p1_cnt !== exp_c[i]) begin
        bad++; $display("FAIL accumulate[%0d]: p=%0d cnt=%0d want %0d %0d", i, p1_p, p1_cnt, exp_p[i], exp_c[i]);
      end
    end
    ce_p = 1'b1; valid_in = 1'b0;
    tick();
    total++; if (p1_v !== 1'b0 || p1_cnt !== 16'd4 || p1_p !== 48'd20) begin
      bad++; $display("FAIL acc_invalid: v=%0b cnt=%0d p=%0d want 0 4 20", p1_v, p1_cnt, p1_p);
    end
  endtask

  task automatic test_illegal_fb();
    z_sel = 2'd2; x_in = 48'd9; cin = 1'b0; sub = 1'b0; valid_in = 1'b1;
    #1;
    total++; if (p0_e !== 1'b1 || p0_p !== 48'd9 || p1_e !== 1'b0) begin
      bad++; $display("FAIL illegal_fb: err0=%0b p=%0d err1=%0b want 1 9 0", p0_e, p0_p, p1_e);
    end
    z_sel = 2'd1; pcin = 48'd1;
    #1;
    total++; if (p0_e !== 1'b0 || p0_p !== 48'd10 || p0_pc !== 48'd10 || p0_v !== 1'b1) begin
      bad++; $display("FAIL legal_cascade: err=%0b p=%0d pc=%0d v=%0b want 0 10 10 1", p0_e, p0_p, p0_pc, p0_v);
    end
    tick();
  endtask

  task automatic test_cnt_sat();
    logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    pulse_reset();
    z_sel = 2'd2; valid_in = 1'b1; ce_p = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (c2_cnt !== exp_c[i]) begin
        bad++; $display("FAIL cnt_sat[%0d]: cnt=%0d want %0d", i, c2_cnt, exp_c[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [47:0] m_p = '0;
    logic        m_c = 1'b0;
    logic        m_v = 1'b0;
    int          m_cnt = 0;
    logic [47:0] z1, z0;
    logic [48:0] r1, r0;
    pulse_reset();
    for (int i = 0; i < 60; i++) begin
      x_in = {$urandom, $urandom};
      c_in = {$urandom, $urandom};
      pcin = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) x_in = ALL1;
      z_sel = 2'($urandom_range(0, 3));
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      valid_in = ($urandom_range(0, 4) != 0);
      ce_p = ($urandom_range(0, 4) != 0);
      z1 = (z_sel == 2'd0) ? 48'd0 : (z_sel == 2'd1) ? pcin : (z_sel == 2'd2) ? m_p : c_in;
      z0 = (z_sel == 2'd2) ? 48'd0 : z1;
      r1 = f_alu(z1, x_in, cin, sub);
      r0 = f_alu(z0, x_in, cin, sub);
      #1;
      total++; if (p0_p !== r0[47:0] || p0_c !== r0[48] || p0_v !== valid_in || p0_e !== (z_sel == 2'd2)) begin
        bad++; $display("FAIL rand_comb[%0d]: p=%h c=%0b v=%0b e=%0b want %h %0b %0b %0b", i,
                        p0_p, p0_c, p0_v, p0_e, r0[47:0], r0[48], valid_in, (z_sel == 2'd2));
      end
      if (ce_p) begin
        m_p = r1[47:0]; m_c = r1[48]; m_v = valid_in;
        if (valid_in) m_cnt = (z_sel == 2'd2) ? ((m_cnt == 65535) ? 65535 : m_cnt + 1) : 1;
      end
      tick();
      total++; if (p1_p !== m_p || p1_pc !== m_p || p1_c !== m_c || p1_v !== m_v || p1_cnt !== 16'(m_cnt)) begin
        bad++; $display("FAIL rand_reg[%0d]: p=%h pc=%h c=%0b v=%0b cnt=%0d want %h %0b %0b %0d", i,
                        p1_p, p1_pc, p1_c, p1_v, p1_cnt, m_p, m_c, m_v, m_cnt);
      end
      total++; if (p0_cnt !== 16'(m_cnt)) begin
        bad++; $display("FAIL rand_cnt0[%0d]: cnt=%0d want %0d", i, p0_cnt, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_carry_wrap();
    test_accumulate();
    test_illegal_fb();
    test_cnt_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
